// File: rtl/activity_stats_if.sv
// Bundle of tracker control strobes and statistics outputs.
// ACTIVITY_PEAK_EN adds the peak-rate output.
interface activity_stats_if;
  logic        i_start;
  logic        i_stepPulse;
  logic        i_secTick;
  logic [15:0] o_totalSteps;
  logic        o_satFlag;
  logic [7:0]  o_distHalfMiles;
  logic [3:0]  o_overThreshSecs;
  logic [15:0] o_highActTime;
`ifdef ACTIVITY_PEAK_EN
  logic [7:0]  o_peakRate;

  modport master (
    output i_start, i_stepPulse, i_secTick,
    input  o_totalSteps, o_satFlag, o_distHalfMiles, o_overThreshSecs,
           o_highActTime, o_peakRate
  );
  modport slave (
    input  i_start, i_stepPulse, i_secTick,
    output o_totalSteps, o_satFlag, o_distHalfMiles, o_overThreshSecs,
           o_highActTime, o_peakRate
  );
`else
  modport master (
    output i_start, i_stepPulse, i_secTick,
    input  o_totalSteps, o_satFlag, o_distHalfMiles, o_overThreshSecs,
           o_highActTime
  );
  modport slave (
    input  i_start, i_stepPulse, i_secTick,
    output o_totalSteps, o_satFlag, o_distHalfMiles, o_overThreshSecs,
           o_highActTime
  );
`endif
endinterface

// File: rtl/activity_stats.sv
// Step/second statistics: total steps, half-mile distance, early-window and
// sustained high-activity seconds. ACTIVITY_PEAK_EN adds a peak steps/second output.
//
// state | meaning
// IDLE  | tracker off, all statistics held at zero
// ARM   | counting steps, waiting for first secTick to align second windows
// RUN   | counting steps and evaluating each second on secTick
module activity_stats #(
  parameter int unsigned STEPS_PER_HALF_MILE = 1024,
  parameter int unsigned LOW_THRESH          = 32,
  parameter int unsigned EARLY_WINDOW        = 9,
  parameter int unsigned HIGH_THRESH         = 64,
  parameter int unsigned HIGH_RUN            = 60,
  parameter int unsigned COUNT_MAX           = 9999
) (
  input logic              i_clk,
  input logic              i_resetN,
  activity_stats_if.slave  io_bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  localparam int HALF_W = (STEPS_PER_HALF_MILE > 1) ? $clog2(STEPS_PER_HALF_MILE) : 1;
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(STEPS_PER_HALF_MILE - 1);
  localparam logic [15:0] CMAX    = 16'(COUNT_MAX);
  localparam logic [7:0]  LOW_T   = 8'(LOW_THRESH);
  localparam logic [7:0]  HIGH_T  = 8'(HIGH_THRESH);
  localparam logic [3:0]  EW      = 4'(EARLY_WINDOW);
  localparam logic [6:0]  HR      = 7'(HIGH_RUN);
  localparam logic [6:0]  HR_MAX  = 7'(HIGH_RUN + 1);

  logic [1:0]        r_state;
  logic [7:0]        r_sec_steps;
  logic [15:0]       r_total;
  logic              r_sat;
  logic [HALF_W-1:0] r_half_acc;
  logic [7:0]        r_dist;
  logic [3:0]        r_over;
  logic [3:0]        r_sec_idx;
  logic [6:0]        r_run_len;
  logic [15:0]       r_high_time;
`ifdef ACTIVITY_PEAK_EN
  logic [7:0]        r_peak;
`endif

  logic        w_step;
  logic        w_tick;
  logic [7:0]  w_eval;
  logic        w_high;
  logic [6:0]  w_run_nxt;
  logic [16:0] w_ht_add;
  logic [16:0] w_ht_sum;
  logic [15:0] w_total_nxt;

  always_comb begin
    w_step = io_bus.i_start && io_bus.i_stepPulse && ((r_state == ARM) || (r_state == RUN));
    w_tick = io_bus.i_start && io_bus.i_secTick && (r_state == RUN);
    // A pulse coincident with the tick belongs to the closing second.
    w_eval = (io_bus.i_stepPulse && (r_sec_steps != 8'hFF)) ? r_sec_steps + 8'd1 : r_sec_steps;
    w_high = (w_eval > HIGH_T);

    w_run_nxt = r_run_len;
    if (!w_high)
      w_run_nxt = '0;
    else if (r_run_len < HR_MAX)
      w_run_nxt = r_run_len + 7'd1;

    // The whole qualifying run is credited at once, then one per extra high second.
    w_ht_add = 17'd0;
    if (w_high && (w_run_nxt == HR))
      w_ht_add = 17'(HIGH_RUN);
    else if (w_high && (w_run_nxt > HR))
      w_ht_add = 17'd1;
    w_ht_sum = {1'b0, r_high_time} + w_ht_add;

    w_total_nxt = (r_total == CMAX) ? r_total : r_total + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      r_state     <= IDLE;
      r_sec_steps <= '0;
      r_total     <= '0;
      r_sat       <= 1'b0;
      r_half_acc  <= '0;
      r_dist      <= '0;
      r_over      <= '0;
      r_sec_idx   <= '0;
      r_run_len   <= '0;
      r_high_time <= '0;
`ifdef ACTIVITY_PEAK_EN
      r_peak      <= '0;
`endif
    end else if (!io_bus.i_start) begin
      r_state     <= IDLE;
      r_sec_steps <= '0;
      r_total     <= '0;
      r_sat       <= 1'b0;
      r_half_acc  <= '0;
      r_dist      <= '0;
      r_over      <= '0;
      r_sec_idx   <= '0;
      r_run_len   <= '0;
      r_high_time <= '0;
`ifdef ACTIVITY_PEAK_EN
      r_peak      <= '0;
`endif
    end else begin
      case (r_state)
        IDLE:    r_state <= ARM;
        ARM:     if (io_bus.i_secTick) r_state <= RUN;
        RUN:     r_state <= RUN;
        default: r_state <= IDLE;
      endcase

      if (w_step) begin
        r_total <= w_total_nxt;
        if (w_total_nxt == CMAX)
          r_sat <= 1'b1;
        // Distance keeps advancing after the step count saturates.
        if (r_half_acc == HALF_LAST) begin
          r_half_acc <= '0;
          if (r_dist != 8'hFF)
            r_dist <= r_dist + 8'd1;
        end else begin
          r_half_acc <= r_half_acc + 1'b1;
        end
      end

      if (w_tick) begin
        r_sec_steps <= '0;
        if (r_sec_idx < EW) begin
          r_sec_idx <= r_sec_idx + 4'd1;
          if (w_eval > LOW_T)
            r_over <= r_over + 4'd1;
        end
        r_run_len   <= w_run_nxt;
        r_high_time <= w_ht_sum[16] ? 16'hFFFF : w_ht_sum[15:0];
`ifdef ACTIVITY_PEAK_EN
        if (w_eval > r_peak)
          r_peak <= w_eval;
`endif
      end else if (w_step && (r_state == RUN) && (r_sec_steps != 8'hFF)) begin
        r_sec_steps <= r_sec_steps + 8'd1;
      end
    end
  end

  assign io_bus.o_totalSteps     = r_total;
  assign io_bus.o_satFlag        = r_sat;
  assign io_bus.o_distHalfMiles  = r_dist;
  assign io_bus.o_overThreshSecs = r_over;
  assign io_bus.o_highActTime    = r_high_time;
`ifdef ACTIVITY_PEAK_EN
  assign io_bus.o_peakRate       = r_peak;
`endif

endmodule

// File: tb/tb_activity_stats.sv
// Directed bench for activity_stats with hand-computed expectations.
module tb_activity_stats;
  logic clk;
  logic resetN;
  int   vectors;
  int   errors;

  activity_stats_if bus ();

  activity_stats dut (
    .i_clk    (clk),
    .i_resetN (resetN),
    .io_bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.i_stepPulse = 1'b1;
    end
    @(negedge clk);
    bus.i_stepPulse = 1'b0;
  endtask

  task automatic tick(input logic coinc);
    @(negedge clk);
    bus.i_secTick   = 1'b1;
    bus.i_stepPulse = coinc;
    @(negedge clk);
    bus.i_secTick   = 1'b0;
    bus.i_stepPulse = 1'b0;
  endtask

  task automatic second(input int n);
    pulses(n);
    tick(1'b0);
  endtask

  task automatic restart();
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    resetN          = 1'b0;
    bus.i_start     = 1'b0;
    bus.i_stepPulse = 1'b0;
    bus.i_secTick   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_total", bus.o_totalSteps, 16'd0);
    check("rst_hat", bus.o_highActTime, 16'd0);
    resetN = 1'b1;

    // start low: strobes ignored
    pulses(20);
    repeat (3) tick(1'b0);
    check("idle_total", bus.o_totalSteps, 16'd0);
    check("idle_over", {12'd0, bus.o_overThreshSecs}, 16'd0);

    // ARM alignment
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    second(5);
    check("arm_total", bus.o_totalSteps, 16'd5);
    check("arm_over", {12'd0, bus.o_overThreshSecs}, 16'd0);
    second(33);
    check("first_sec_over", {12'd0, bus.o_overThreshSecs}, 16'd1);
    check("first_sec_total", bus.o_totalSteps, 16'd38);

    // low-threshold boundaries
    second(32);
    check("exact32_over", {12'd0, bus.o_overThreshSecs}, 16'd1);
    second(33);
    check("thresh33_over", {12'd0, bus.o_overThreshSecs}, 16'd2);
    pulses(32);
    tick(1'b1);
    check("coinc_over", {12'd0, bus.o_overThreshSecs}, 16'd3);
    check("coinc_total", bus.o_totalSteps, 16'd136);

    // asynchronous reset mid-count
    @(negedge clk);
    resetN = 1'b0;
    #1;
    check("async_rst_total", bus.o_totalSteps, 16'd0);
    check("async_rst_over", {12'd0, bus.o_overThreshSecs}, 16'd0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);

    // early window closes after 9 evaluated ticks
    tick(1'b0);
    for (int s = 0; s < 9; s++) second(40);
    check("window9_over", {12'd0, bus.o_overThreshSecs}, 16'd9);
    second(40);
    check("window_closed_over", {12'd0, bus.o_overThreshSecs}, 16'd9);
    check("window_total", bus.o_totalSteps, 16'd400);

    // sustained high activity
    restart();
    check("restart_total", bus.o_totalSteps, 16'd0);
    tick(1'b0);
    for (int s = 0; s < 59; s++) second(65);
    check("hat_59", bus.o_highActTime, 16'd0);
    second(65);
    check("hat_60", bus.o_highActTime, 16'd60);
    second(65);
    check("hat_61", bus.o_highActTime, 16'd61);
    second(64);
    check("hat_break", bus.o_highActTime, 16'd61);
    for (int s = 0; s < 59; s++) second(65);
    check("hat_short_run", bus.o_highActTime, 16'd61);
    second(65);
    check("hat_second_run", bus.o_highActTime, 16'd121);
    check("hat_total", bus.o_totalSteps, 16'd7929);
    check("hat_dist", {8'd0, bus.o_distHalfMiles}, 16'd7);

    // distance and saturation (steps count in ARM)
    restart();
    pulses(2048);
    check("dist_2048", {8'd0, bus.o_distHalfMiles}, 16'd2);
    check("total_2048", bus.o_totalSteps, 16'd2048);
    pulses(7950);
    check("total_9998", bus.o_totalSteps, 16'd9998);
    check("sat_9998", {15'd0, bus.o_satFlag}, 16'd0);
    pulses(1);
    check("total_9999", bus.o_totalSteps, 16'd9999);
    check("sat_9999", {15'd0, bus.o_satFlag}, 16'd1);
    pulses(6);
    check("total_sat", bus.o_totalSteps, 16'd9999);
    check("dist_10005", {8'd0, bus.o_distHalfMiles}, 16'd9);

    // single-cycle start drop clears on the next edge
    @(negedge clk);
    bus.i_start = 1'b0;
    @(posedge clk);
    #1;
    check("drop_total", bus.o_totalSteps, 16'd0);
    check("drop_sat", {15'd0, bus.o_satFlag}, 16'd0);
    check("drop_dist", {8'd0, bus.o_distHalfMiles}, 16'd0);
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);

`ifdef ACTIVITY_PEAK_EN
    tick(1'b0);
    second(40);
    second(90);
    second(70);
    check("peak_90", {8'd0, bus.o_peakRate}, 16'd90);
    restart();
    check("peak_clear", {8'd0, bus.o_peakRate}, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
